// File: rtl/draw_sprite_blit.sv
// rtl/draw_sprite_blit.sv - sprite blitter: scans a sprite ROM row-major and emits clipped, colour-keyed VGA plots
module draw_sprite_blit #(
   parameter int              SPR_W      = 80,
   parameter int              SPR_H      = 40,
   parameter int              ADDR_W     = 12,
   parameter int              COL_W      = 9,
   parameter int              ROM_LAT    = 1,
   parameter int              SCREEN_W   = 160,
   parameter int              SCREEN_H   = 120,
   parameter bit              TRANSP_EN  = 1'b0,
   parameter logic [COL_W-1:0] TRANSP_KEY = '0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              abort,
   input  logic [7:0]        x0,
   input  logic [6:0]        y0,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [COL_W-1:0]  rom_q,
   output logic              busy,
   output logic              done,
   output logic [7:0]        x,
   output logic [6:0]        y,
   output logic [COL_W-1:0]  colour,
   output logic              plot
);

   localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(SPR_H - 1);
   localparam logic [8:0]    SCR_W9   = 9'(SCREEN_W);
   localparam logic [7:0]    SCR_H8   = 8'(SCREEN_H);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
   state_t state, state_nx;

   logic [7:0]    ox;
   logic [6:0]    oy;
   logic [CW-1:0] a_col;
   logic [RW-1:0] a_row;
   logic [CW-1:0] p_col [ROM_LAT];
   logic [RW-1:0] p_row [ROM_LAT];
   logic [ROM_LAT-1:0] p_valid;

   logic accept, kill, last_addr, tail_valid, clipped, transparent;
   logic [8:0] xs;
   logic [7:0] ys;

   // While in RUN the address register always holds a live request.
   assign accept    = (state == IDLE) && start;
   assign kill      = abort && ((state == RUN) || (state == DRAIN));
   assign last_addr = (state == RUN) && (a_col == COL_LAST) && (a_row == ROW_LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (kill) state_nx = IDLE;
                  else if (last_addr) state_nx = DRAIN;
         DRAIN:   if (kill) state_nx = IDLE;
                  else if (p_valid == '0) state_nx = FIN;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN) || (state == DRAIN);
      done = (state == FIN);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ox       <= '0;
         oy       <= '0;
         a_col    <= '0;
         a_row    <= '0;
         mem_addr <= '0;
      end else if (accept) begin
         ox       <= x0;
         oy       <= y0;
         a_col    <= '0;
         a_row    <= '0;
         mem_addr <= '0;
      end else if ((state == RUN) && !last_addr) begin
         mem_addr <= mem_addr + ADDR_W'(1);
         if (a_col == COL_LAST) begin
            a_col <= '0;
            a_row <= a_row + RW'(1);
         end else begin
            a_col <= a_col + CW'(1);
         end
      end
   end

   // Coordinates ride alongside the ROM read so they meet rom_q at the tail.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         p_valid <= '0;
         for (int i = 0; i < ROM_LAT; i++) begin
            p_col[i] <= '0;
            p_row[i] <= '0;
         end
      end else begin
         for (int i = ROM_LAT - 1; i > 0; i--) begin
            p_valid[i] <= p_valid[i-1];
            p_col[i]   <= p_col[i-1];
            p_row[i]   <= p_row[i-1];
         end
         p_valid[0] <= (state == RUN);
         p_col[0]   <= a_col;
         p_row[0]   <= a_row;
         if (kill) p_valid <= '0;
      end
   end

   assign tail_valid  = p_valid[ROM_LAT-1];
   assign xs          = {1'b0, ox} + 9'(p_col[ROM_LAT-1]);
   assign ys          = {1'b0, oy} + 8'(p_row[ROM_LAT-1]);
   assign clipped     = (xs >= SCR_W9) || (ys >= SCR_H8);
   assign transparent = TRANSP_EN && (rom_q == TRANSP_KEY);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         plot   <= 1'b0;
         x      <= '0;
         y      <= '0;
         colour <= '0;
      end else if (kill) begin
         plot <= 1'b0;
      end else begin
         plot <= tail_valid && !clipped && !transparent;
         if (tail_valid) begin
            x      <= xs[7:0];
            y      <= ys[6:0];
            colour <= rom_q;
         end
      end
   end

endmodule

// File: tb/tb_draw_sprite_blit.sv
// tb/tb_draw_sprite_blit.sv - randomized self-checking bench for draw_sprite_blit
module tb_draw_sprite_blit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetn;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // instance A: default geometry, ROM latency 1
   logic        start_a, abort_a, busy_a, done_a, plot_a;
   logic [7:0]  x0_a, x_a;
   logic [6:0]  y0_a, y_a;
   logic [11:0] addr_a;
   logic [8:0]  q_a, col_a;
   logic [8:0]  rom_a [0:4095];

   // instance B: 4x4, colour key 0, ROM latency 3
   logic        start_b, abort_b, busy_b, done_b, plot_b;
   logic [7:0]  x0_b, x_b;
   logic [6:0]  y0_b, y_b;
   logic [3:0]  addr_b;
   logic [8:0]  q_b, col_b, qb_d1, qb_d2;
   logic [8:0]  rom_b [0:15];

   draw_sprite_blit dut_a (
      .clk(clk), .resetn(resetn), .start(start_a), .abort(abort_a), .x0(x0_a), .y0(y0_a),
      .mem_addr(addr_a), .rom_q(q_a), .busy(busy_a), .done(done_a), .x(x_a), .y(y_a),
      .colour(col_a), .plot(plot_a));

   draw_sprite_blit #(.SPR_W(4), .SPR_H(4), .ADDR_W(4), .ROM_LAT(3), .TRANSP_EN(1'b1),
                      .TRANSP_KEY(9'h0)) dut_b (
      .clk(clk), .resetn(resetn), .start(start_b), .abort(abort_b), .x0(x0_b), .y0(y0_b),
      .mem_addr(addr_b), .rom_q(q_b), .busy(busy_b), .done(done_b), .x(x_b), .y(y_b),
      .colour(col_b), .plot(plot_b));

   always @(posedge clk) begin
      q_a   <= rom_a[addr_a];
      qb_d1 <= rom_b[addr_b];
      qb_d2 <= qb_d1;
      q_b   <= qb_d2;
   end

   typedef struct { int c; int x; int y; int col; } ev_t;
   ev_t ev_a[$], ev_b[$];
   int  dn_a[$], dn_b[$];
   int  bz_a = 0, bz_b = 0;

   always @(negedge clk) begin
      ev_t e;
      if (plot_a) begin
         e.c = cyc; e.x = int'(x_a); e.y = int'(y_a); e.col = int'(col_a);
         ev_a.push_back(e);
      end
      if (plot_b) begin
         e.c = cyc; e.x = int'(x_b); e.y = int'(y_b); e.col = int'(col_b);
         ev_b.push_back(e);
      end
      if (done_a) dn_a.push_back(cyc);
      if (done_b) dn_b.push_back(cyc);
      if (busy_a) bz_a = bz_a + 1;
      if (busy_b) bz_b = bz_b + 1;
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Drives a one-cycle start at the current negedge; s is cycle 0 of the blit.
   task automatic start_run(input int sel, input int ox, input int oy, output int s,
                            output int eb, output int db, output int bb);
      eb = (sel == 0) ? ev_a.size() : ev_b.size();
      db = (sel == 0) ? dn_a.size() : dn_b.size();
      bb = (sel == 0) ? bz_a : bz_b;
      s  = cyc;
      if (sel == 0) begin x0_a = 8'(ox); y0_a = 7'(oy); start_a = 1'b1; end
      else          begin x0_b = 8'(ox); y0_b = 7'(oy); start_b = 1'b1; end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      chk("busy_cycle1", (sel == 0) ? int'(busy_a) : int'(busy_b), 1);
   endtask

   // Reference: every sprite pixel lands ROM_LAT+2 cycles after its issue slot.
   task automatic check_run(input int sel, input int s, input int ox, input int oy,
                            input int cutoff, input int eb, input int db, input int bb,
                            input string tag);
      int W, H, L, tr, n, mism, bz;
      ev_t exp_q[$], got[$], e;
      int dn[$];
      W = (sel == 0) ? 80 : 4;
      H = (sel == 0) ? 40 : 4;
      L = (sel == 0) ? 1 : 3;
      tr = (sel == 0) ? 0 : 1;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            int a, pc, colr;
            a    = r * W + c;
            colr = (sel == 0) ? int'(rom_a[a]) : int'(rom_b[a]);
            pc   = s + 1 + a + L + 1;
            if ((cutoff < 0 || pc <= cutoff) && (ox + c) < 160 && (oy + r) < 120 &&
                !(tr == 1 && colr == 0)) begin
               e.c = pc; e.x = ox + c; e.y = oy + r; e.col = colr;
               exp_q.push_back(e);
            end
         end
      end
      if (sel == 0) begin
         for (int i = eb; i < ev_a.size(); i++) got.push_back(ev_a[i]);
         for (int i = db; i < dn_a.size(); i++) dn.push_back(dn_a[i]);
         bz = bz_a - bb;
      end else begin
         for (int i = eb; i < ev_b.size(); i++) got.push_back(ev_b[i]);
         for (int i = db; i < dn_b.size(); i++) dn.push_back(dn_b[i]);
         bz = bz_b - bb;
      end
      chk({tag, "_plot_count"}, got.size(), exp_q.size());
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      mism = 0;
      for (int i = 0; i < n; i++)
         if (got[i].c != exp_q[i].c || got[i].x != exp_q[i].x || got[i].y != exp_q[i].y ||
             got[i].col != exp_q[i].col) mism++;
      chk({tag, "_plot_mismatches"}, mism, 0);
      if (cutoff < 0) begin
         chk({tag, "_done_count"}, dn.size(), 1);
         if (dn.size() > 0) chk({tag, "_done_cycle"}, dn[0] - s, W * H + L + 2);
         chk({tag, "_busy_cycles"}, bz, W * H + L + 1);
      end else begin
         chk({tag, "_done_count"}, dn.size(), 0);
      end
   endtask

   initial begin
      int s, eb, db, bb, ox, oy, k, p;
      resetn = 1'b0;
      start_a = 0; abort_a = 0; x0_a = 0; y0_a = 0;
      start_b = 0; abort_b = 0; x0_b = 0; y0_b = 0;
      for (int i = 0; i < 4096; i++) rom_a[i] = 9'($urandom_range(1, 511));
      for (int i = 0; i < 16; i++)   rom_b[i] = 9'($urandom_range(1, 511));
      k = 0;
      while (k < 5) begin
         p = $urandom_range(0, 15);
         if (rom_b[p] != 0) begin rom_b[p] = 9'h0; k++; end
      end
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_done", int'(done_a), 0);
      chk("rst_plot", int'(plot_a), 0);
      chk("rst_addr", int'(addr_a), 0);
      chk("rst_xyc", int'({x_a, y_a, col_a}), 0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // full sprite at (39,39), every word nonzero
      start_run(0, 39, 39, s, eb, db, bb);
      wait_to(s + 3210);
      check_run(0, s, 39, 39, -1, eb, db, bb, "a_full");
      if (ev_a.size() > eb) begin
         chk("a_first_cycle", ev_a[eb].c - s, 3);
         chk("a_first_xy", ev_a[eb].x * 256 + ev_a[eb].y, 39 * 256 + 39);
         chk("a_last_cycle", ev_a[ev_a.size()-1].c - s, 3202);
         chk("a_last_xy", ev_a[ev_a.size()-1].x * 256 + ev_a[ev_a.size()-1].y, 118 * 256 + 78);
      end else chk("a_first_plot_seen", 0, 1);

      // edge clipping
      start_run(0, 150, 115, s, eb, db, bb);
      wait_to(s + 3210);
      check_run(0, s, 150, 115, -1, eb, db, bb, "a_clip");
      chk("a_clip_count", ev_a.size() - eb, 50);

      // random ROM with zeros, random origin, stray start mid-run
      for (int i = 0; i < 4096; i++) rom_a[i] = 9'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 511));
      ox = $urandom_range(0, 159); oy = $urandom_range(0, 119);
      start_run(0, ox, oy, s, eb, db, bb);
      wait_to(s + 50);
      x0_a = 8'($urandom_range(0, 255)); y0_a = 7'($urandom_range(0, 127)); start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_to(s + 3210);
      check_run(0, s, ox, oy, -1, eb, db, bb, "a_rand");

      // abort at pixel 100, then restart
      start_run(0, 20, 30, s, eb, db, bb);
      wait_to(s + 100);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      chk("abort_busy", int'(busy_a), 0);
      chk("abort_plot", int'(plot_a), 0);
      @(negedge clk);
      check_run(0, s, 20, 30, s + 100, eb, db, bb, "a_abort");
      start_run(0, 7, 9, s, eb, db, bb);
      wait_to(s + 3210);
      check_run(0, s, 7, 9, -1, eb, db, bb, "a_restart");

      // asynchronous reset mid-run
      start_run(0, 5, 5, s, eb, db, bb);
      wait_to(s + 500);
      #2 resetn = 1'b0;
      #1;
      chk("arst_busy", int'(busy_a), 0);
      chk("arst_plot", int'(plot_a), 0);
      chk("arst_addr", int'(addr_a), 0);
      chk("arst_xyc", int'({x_a, y_a, col_a}), 0);
      @(negedge clk);
      resetn = 1'b1;
      eb = ev_a.size(); db = dn_a.size();
      repeat (10) @(negedge clk);
      chk("arst_idle_plots", ev_a.size() - eb, 0);
      chk("arst_idle_done", dn_a.size() - db, 0);
      chk("arst_idle_busy", int'(busy_a), 0);

      // colour key with ROM latency 3
      start_run(1, 10, 10, s, eb, db, bb);
      wait_to(s + 30);
      check_run(1, s, 10, 10, -1, eb, db, bb, "b_key");
      chk("b_key_count", ev_b.size() - eb, 11);
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < 16; i++) rom_b[i] = 9'($urandom_range(0, 1) == 0 ? 0 : $urandom_range(0, 511));
         ox = $urandom_range(150, 159); oy = $urandom_range(110, 119);
         start_run(1, ox, oy, s, eb, db, bb);
         wait_to(s + 30);
         check_run(1, s, ox, oy, -1, eb, db, bb, "b_rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
